// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM state encoding and the
// per-frame configuration captured on a start request.
package spi_pkg;

   localparam int SPI_MAX_DATA_W = 32;
   localparam int SPI_MAX_DIV_W  = 16;
   localparam int SPI_MAX_SS_W   = 4;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      XFER,
      TRAIL,
      DONE
   } spi_state_e;

   typedef struct packed {
      logic                     msb;
      logic                     cpol;
      logic                     cpha;
      logic [SPI_MAX_DIV_W-1:0] div;
      logic [SPI_MAX_SS_W-1:0]  ss_sel;
   } spi_cfg_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one-cycle tick every div+1 clk cycles while
// enabled, counter held at zero when disabled.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [SPI_MAX_DIV_W-1:0] div,
   output logic                     tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign tick = en && (SPI_MAX_DIV_W'(cnt_q) == div);

   always_comb begin
      cnt_d = '0;
      if (en && !tick) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master_multi.sv
// Full-duplex SPI master: DATA_W-bit frames, CPOL/CPHA modes, programmable
// SCLK divider, NUM_SS selects. Optional SPI_LOOPBACK_EN adds SPI_loopback.
//
// state | meaning
// IDLE  | selects high, SCLK at latched cpol, wait for start rising edge
// LEAD  | one half-period with select low before the first SCLK edge
// XFER  | 2*DATA_W SCLK edges, one per half-period tick
// TRAIL | one half-period with SCLK idle and select still low
// DONE  | one cycle: release select, publish received frame, pulse flag
module spi_master_multi
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4,
   parameter int DIV_W  = 4
) (
   input  logic                                          clk,
   input  logic                                          SPI_reset,
   input  logic [DATA_W-1:0]                             SPI_data_trans,
   input  logic                                          SPI_MSB,
   input  logic                                          SPI_cpol,
   input  logic                                          SPI_cpha,
   input  logic [DIV_W-1:0]                              SPI_div,
   input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] SPI_ss_sel,
   input  logic                                          SPI_start,
   input  logic                                          SPI_miso,
`ifdef SPI_LOOPBACK_EN
   input  logic                                          SPI_loopback,
`endif
   output logic                                          SPI_sclk,
   output logic                                          SPI_mosi,
   output logic [NUM_SS-1:0]                             SPI_slave_select,
   output logic [DATA_W-1:0]                             SPI_data_rec,
   output logic                                          SPI_busy,
   output logic                                          SPI_flag
);

   localparam int CNT_W = $clog2(2 * DATA_W);
   localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

   if (DATA_W < 2 || DATA_W > SPI_MAX_DATA_W) begin : g_bad_data_w
      $error("spi_master_multi: DATA_W out of range");
   end

   spi_state_e        state_q, state_d;
   spi_cfg_t          cfg_q, cfg_d;
   logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, data_rec_q, data_rec_d;
   logic [CNT_W-1:0]  edge_q, edge_d;
   logic              start_prev_q;
   logic              sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, flag_q, flag_d;
   logic [NUM_SS-1:0] ss_q, ss_d, sel_mask;
   logic              tick, clk_en, start_rise, rx_bit, cur_bit, next_bit, sample_edge;
   logic [DATA_W-1:0] tx_shifted;

   assign start_rise  = SPI_start & ~start_prev_q;
   assign clk_en      = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL);
   assign cur_bit     = cfg_q.msb ? tx_q[DATA_W-1] : tx_q[0];
   assign next_bit    = cfg_q.msb ? tx_q[DATA_W-2] : tx_q[1];
   assign tx_shifted  = cfg_q.msb ? {tx_q[DATA_W-2:0], 1'b0} : {1'b0, tx_q[DATA_W-1:1]};
   // Even edge count is the leading edge; cpha flips which edge samples.
   assign sample_edge = ~edge_q[0] ^ cfg_q.cpha;

`ifdef SPI_LOOPBACK_EN
   assign rx_bit = SPI_loopback ? mosi_q : SPI_miso;
`else
   assign rx_bit = SPI_miso;
`endif

   spi_clk_gen #(
      .DIV_W (DIV_W)
   ) u_clk_gen (
      .clk   (clk),
      .rst_n (SPI_reset),
      .en    (clk_en),
      .div   (cfg_q.div),
      .tick  (tick)
   );

   // Out-of-range selects leave every line high.
   always_comb begin
      sel_mask = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (cfg_q.ss_sel == SPI_MAX_SS_W'(i)) begin
            sel_mask[i] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      edge_d     = edge_q;
      data_rec_d = data_rec_q;
      sclk_d     = cfg_q.cpol;
      mosi_d     = mosi_q;
      ss_d       = '1;
      busy_d     = 1'b0;
      flag_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            mosi_d = 1'b0;
            // The cycle after DONE still shows the flag; starts there are dropped too.
            if (start_rise && !flag_q) begin
               cfg_d.msb    = SPI_MSB;
               cfg_d.cpol   = SPI_cpol;
               cfg_d.cpha   = SPI_cpha;
               cfg_d.div    = SPI_MAX_DIV_W'(SPI_div);
               cfg_d.ss_sel = SPI_MAX_SS_W'(SPI_ss_sel);
               tx_d         = SPI_data_trans;
               rx_d         = '0;
               edge_d       = '0;
               sclk_d       = SPI_cpol;
               state_d      = LEAD;
            end
         end
         LEAD: begin
            busy_d = 1'b1;
            ss_d   = sel_mask;
            mosi_d = cfg_q.cpha ? 1'b0 : cur_bit;
            if (tick) begin
               state_d = XFER;
            end
         end
         XFER: begin
            busy_d = 1'b1;
            ss_d   = sel_mask;
            sclk_d = sclk_q;
            if (tick) begin
               sclk_d = ~sclk_q;
               edge_d = edge_q + CNT_W'(1);
               if (sample_edge) begin
                  rx_d = cfg_q.msb ? {rx_q[DATA_W-2:0], rx_bit} : {rx_bit, rx_q[DATA_W-1:1]};
               end else if (cfg_q.cpha) begin
                  mosi_d = cur_bit;
                  tx_d   = tx_shifted;
               end else if (edge_q != LAST_EDGE) begin
                  mosi_d = next_bit;
                  tx_d   = tx_shifted;
               end
               if (edge_q == LAST_EDGE) begin
                  state_d = TRAIL;
               end
            end
         end
         TRAIL: begin
            busy_d = 1'b1;
            ss_d   = sel_mask;
            if (tick) begin
               state_d = DONE;
            end
         end
         DONE: begin
            mosi_d     = 1'b0;
            flag_d     = 1'b1;
            data_rec_d = rx_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge SPI_reset) begin
      if (!SPI_reset) begin
         state_q      <= IDLE;
         cfg_q        <= '0;
         tx_q         <= '0;
         rx_q         <= '0;
         edge_q       <= '0;
         data_rec_q   <= '0;
         start_prev_q <= 1'b1;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         ss_q         <= '1;
         busy_q       <= 1'b0;
         flag_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         edge_q       <= edge_d;
         data_rec_q   <= data_rec_d;
         start_prev_q <= SPI_start;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         ss_q         <= ss_d;
         busy_q       <= busy_d;
         flag_q       <= flag_d;
      end
   end

   assign SPI_sclk         = sclk_q;
   assign SPI_mosi         = mosi_q;
   assign SPI_slave_select = ss_q;
   assign SPI_data_rec     = data_rec_q;
   assign SPI_busy         = busy_q;
   assign SPI_flag         = flag_q;

endmodule
